psg_io_writer: RTL and testbench

- Bus initiator for the PSG. It is the CPU-side counterpart to the PSG's bus slave port.
- Accepts sound-register bytes from an internal producer (test sequencer or sound driver) through a valid/ready port and buffers them in a small FIFO.
- Replays each byte as a Z80-style I/O write cycle (OUT (PSG_PORT),A) on the shared data/address buses, with bus arbitration and wait-state support.

---
 rtl/psg_pkg.sv | 35 +++
 rtl/psg_cmd_fifo.sv | 64 ++++++
 rtl/psg_io_writer.sv | 123 ++++++++++++
 tb/tb_psg_io_writer.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/psg_pkg.sv
// Shared types and constants for the PSG I/O write path.
// SN76489 byte-field positions live here for drivers and benches.
package psg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    T1,
    T2,
    TW,
    T3,
    GAP
  } wr_state_t;

  localparam logic [7:0] PSG_PORT_DEFAULT = 8'h7F;

  localparam int SN_LATCH_BIT = 7;
  localparam int SN_CH_HI     = 6;
  localparam int SN_CH_LO     = 5;
  localparam int SN_TYPE_BIT  = 4;

  function automatic logic [7:0] sn_latch(
    input logic [1:0] ch,
    input logic       typ,
    input logic [3:0] val
  );
    logic [7:0] b;
    b = {4'h0, val};
    b[SN_LATCH_BIT] = 1'b1;
    b[SN_CH_HI]     = ch[1];
    b[SN_CH_LO]     = ch[0];
    b[SN_TYPE_BIT]  = typ;
    return b;
  endfunction

endpackage

// File: rtl/psg_cmd_fifo.sv
// Small synchronous FIFO for PSG command bytes.
// The read-side empty flag drops one clock after the first write.
module psg_cmd_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [W-1:0]               wdata,
  input  logic                       pop,
  output logic [W-1:0]               rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic          do_push;
  logic          do_pop;
  logic [AW:0]   cnt_nxt;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rp];

  always_comb begin
    cnt_nxt = count;
    if (do_push && !do_pop)
      cnt_nxt = count + 1'b1;
    else if (!do_push && do_pop)
      cnt_nxt = count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wp] <= wdata;
  end

  // A fresh byte sits one clock before the reader sees it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (do_push)
        wp <= wp + 1'b1;
      if (do_pop)
        rp <= rp + 1'b1;
      count <= cnt_nxt;
      full  <= (cnt_nxt == FULL_CNT);
      empty <= (cnt_nxt == '0) || (count == '0);
    end
  end

endmodule

// File: rtl/psg_io_writer.sv
// Replays buffered PSG bytes as Z80 OUT (n),A bus cycles.
// Strobes are flops; bus enables decode the state register only.
module psg_io_writer
  import psg_pkg::*;
#(
  parameter logic [7:0] PSG_PORT   = PSG_PORT_DEFAULT,
  parameter int         FIFO_DEPTH = 4,
  parameter int         GAP_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  cmd_data,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  output logic        bus_req,
  input  logic        bus_gnt,
  input  logic        wait_n,
  output logic        iorq_n,
  output logic        wr_n,
  inout  wire  [7:0]  data_bus,
  inout  wire  [15:0] addr_bus,
  output logic        busy,
  output logic        wr_done
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LOAD =
    (GAP_CYCLES > 1) ? GW'(GAP_CYCLES - 2) : '0;

  wr_state_t     state;
  logic [7:0]    dout;
  logic [GW-1:0] gap_cnt;
  logic          drive;
  logic          push;
  logic          pop;
  logic [7:0]    head;
  logic          full;
  logic          empty;
  logic [AW:0]   count;

  assign cmd_ready = !full;
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state == T3);

  psg_cmd_fifo #(
    .W     (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (cmd_data),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign drive = (state == T1) || (state == T2) ||
                 (state == TW) || (state == T3);

  assign addr_bus = drive ? {dout, PSG_PORT} : 'z;
  assign data_bus = drive ? dout : 'z;

  assign bus_req = drive || ((state == IDLE) && !empty);
  assign busy    = (count != '0) || (state != IDLE);

  // GAP plus the IDLE clock make up the enforced idle time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      dout    <= '0;
      gap_cnt <= '0;
      iorq_n  <= 1'b1;
      wr_n    <= 1'b1;
      wr_done <= 1'b0;
    end else begin
      wr_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus_gnt && !empty) begin
            state <= T1;
            dout  <= head;
          end
        end
        T1: begin
          state  <= T2;
          iorq_n <= 1'b0;
          wr_n   <= 1'b0;
        end
        T2: begin
          state <= TW;
        end
        TW: begin
          if (wait_n) begin
            state   <= T3;
            iorq_n  <= 1'b1;
            wr_n    <= 1'b1;
            wr_done <= 1'b1;
          end
        end
        T3: begin
          if (GAP_CYCLES > 1) begin
            state   <= GAP;
            gap_cnt <= GAP_LOAD;
          end else begin
            state <= IDLE;
          end
        end
        GAP: begin
          if (gap_cnt == '0)
            state <= IDLE;
          else
            gap_cnt <= gap_cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_psg_io_writer.sv
// Bench for psg_io_writer: directed bus-cycle checks plus a
// randomized run scored against a byte-queue reference model.
module tb_psg_io_writer;
  import psg_pkg::*;

  localparam int GAPC  = 4;
  localparam int PER   = 4 + GAPC;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  cmd_data;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        bus_req;
  logic        bus_gnt;
  logic        wait_n;
  logic        iorq_n;
  logic        wr_n;
  logic        busy;
  logic        wr_done;
  wire  [7:0]  data_bus;
  wire  [15:0] addr_bus;

  for (genvar g = 0; g < 16; g++) begin : g_pa
    pullup (addr_bus[g]);
  end
  for (genvar g = 0; g < 8; g++) begin : g_pd
    pullup (data_bus[g]);
  end

  psg_io_writer #(
    .PSG_PORT   (8'h7F),
    .FIFO_DEPTH (DEPTH),
    .GAP_CYCLES (GAPC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_data  (cmd_data),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .bus_req   (bus_req),
    .bus_gnt   (bus_gnt),
    .wait_n    (wait_n),
    .iorq_n    (iorq_n),
    .wr_n      (wr_n),
    .data_bus  (data_bus),
    .addr_bus  (addr_bus),
    .busy      (busy),
    .wr_done   (wr_done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_push  = 0;
  int n_done  = 0;
  int n_wr    = 0;
  int last_len = 0;
  int starts[$];
  logic [7:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Protocol monitor: captures each write and scores it.
  logic        inflt = 1'b0;
  logic        rel_pend = 1'b0;
  int          len = 0;
  int          exp_len = 0;
  logic [15:0] cap_a;
  logic [7:0]  cap_d;

  always @(negedge clk) begin
    logic low;
    logic t3;
    logic [7:0] e;
    if (!rst_n) begin
      inflt = 1'b0;
      rel_pend = 1'b0;
      n_done = 0;
      exp_q.delete();
    end else begin
      chk("ready_model", cmd_ready, (n_push - n_done) < DEPTH);
      low = !iorq_n;
      t3  = !low && inflt;
      chk("strobes_eq", wr_n, iorq_n);
      chk("done_pulse", wr_done, t3);
      if (wr_done)
        n_done++;
      if (low && !inflt) begin
        inflt = 1'b1;
        len = 1;
        exp_len = 0;
        cap_a = addr_bus;
        cap_d = data_bus;
        chk("addr_form", cap_a, {cap_d, 8'h7F});
        if (starts.size() > 0)
          chk("min_period", (cyc - starts[$]) >= PER, 1);
        starts.push_back(cyc);
      end else if (low) begin
        len++;
        chk("hold_addr", addr_bus, cap_a);
        chk("hold_data", data_bus, cap_d);
        if (exp_len == 0 && wait_n)
          exp_len = len;
      end else if (t3) begin
        inflt = 1'b0;
        n_wr++;
        last_len = len;
        chk("strobe_len", len, exp_len);
        chk("t3_addr", addr_bus, cap_a);
        chk("t3_data", data_bus, cap_d);
        chk("t3_req", bus_req, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("wr_byte", cap_d, e);
        end else begin
          chk("wr_unexpected", exp_q.size(), 1);
        end
        rel_pend = 1'b1;
      end else if (rel_pend) begin
        rel_pend = 1'b0;
        chk("gap_release", addr_bus, 16'hFFFF);
        chk("gap_req", bus_req, 0);
      end
    end
  end

  task automatic push(input logic [7:0] b);
    logic r;
    int n;
    n = 0;
    r = 1'b0;
    cmd_data  = b;
    cmd_valid = 1'b1;
    while (!r && n < 100) begin
      @(negedge clk);
      r = cmd_ready;
      tick();
      n++;
    end
    cmd_valid = 1'b0;
    if (r) begin
      exp_q.push_back(b);
      n_push++;
    end
    chk("push_accept", r, 1);
  endtask

  task automatic wait_low(input string tag);
    int n;
    n = 0;
    while (iorq_n && n < 200) begin
      tick();
      n++;
    end
    chk(tag, n < 200, 1);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < 600) begin
      tick();
      n++;
    end
    chk(tag, n < 600, 1);
    repeat (2) tick();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] b2b [4];
    int bs, base, w0, n;
    b2b = '{8'h80, 8'h0A, 8'h9F, 8'hBF};
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_data = 8'h00;
    bus_gnt = 1'b0;
    wait_n = 1'b1;
    repeat (2) tick();
    chk("rst_iorq", iorq_n, 1);
    chk("rst_wr", wr_n, 1);
    chk("rst_req", bus_req, 0);
    chk("rst_done", wr_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_addr", addr_bus, 16'hFFFF);
    chk("rst_data", data_bus, 8'hFF);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // single write
    bus_gnt = 1'b1;
    push(8'h9F);
    chk("s_busy", busy, 1);
    tick();
    chk("s_req", bus_req, 1);
    chk("s_idle_addr", addr_bus, 16'hFFFF);
    tick();
    chk("s_t1_addr", addr_bus, 16'h9F7F);
    chk("s_t1_data", data_bus, 8'h9F);
    chk("s_t1_iorq", iorq_n, 1);
    tick();
    chk("s_t2_iorq", iorq_n, 0);
    chk("s_t2_wr", wr_n, 0);
    tick();
    chk("s_tw_iorq", iorq_n, 0);
    tick();
    chk("s_t3_iorq", iorq_n, 1);
    chk("s_t3_done", wr_done, 1);
    chk("s_t3_addr", addr_bus, 16'h9F7F);
    tick();
    chk("s_gap_addr", addr_bus, 16'hFFFF);
    chk("s_gap_data", data_bus, 8'hFF);
    chk("s_gap_done", wr_done, 0);
    wait_idle("s_idle_to");
    chk("s_len", last_len, 2);

    // back-to-back
    bs = starts.size();
    for (int i = 0; i < 4; i++) begin
      chk("b_ready", cmd_ready, 1);
      push(b2b[i]);
    end
    chk("b_full", cmd_ready, 0);
    wait_idle("b_idle_to");
    chk("b_count", starts.size() - bs, 4);
    if (starts.size() - bs == 4)
      for (int i = 0; i < 3; i++)
        chk("b_period", starts[bs+i+1] - starts[bs+i], PER);

    // overflow back-pressure
    bus_gnt = 1'b0;
    for (int i = 0; i < 4; i++)
      push(sn_latch(2'(i), 1'b0, 4'(i + 3)));
    chk("o_full", cmd_ready, 0);
    base = n_done;
    fork
      push(sn_latch(2'd3, 1'b1, 4'hF));
      begin
        repeat (8) tick();
        chk("o_hold", cmd_ready, 0);
        chk("o_req", bus_req, 1);
        chk("o_z", addr_bus, 16'hFFFF);
        bus_gnt = 1'b1;
      end
    join
    chk("o_accept_after_done", n_done - base, 1);
    wait_idle("o_idle_to");

    // wait states
    push(8'h91);
    wait_low("w_low_to");
    wait_n = 1'b0;
    repeat (4) begin
      tick();
      chk("w_iorq", iorq_n, 0);
      chk("w_data", data_bus, 8'h91);
    end
    wait_n = 1'b1;
    tick();
    chk("w_t3", iorq_n, 1);
    chk("w_done", wr_done, 1);
    wait_idle("w_idle_to");
    chk("w_len", last_len, 5);

    // grant timing
    bus_gnt = 1'b0;
    push(8'hA3);
    push(8'hC5);
    w0 = n_wr;
    repeat (5) begin
      tick();
      chk("g_z", addr_bus, 16'hFFFF);
      chk("g_req", bus_req, 1);
    end
    bus_gnt = 1'b1;
    wait_low("g_low_to");
    bus_gnt = 1'b0;
    n = 0;
    while (n_wr == w0 && n < 50) begin
      tick();
      n++;
    end
    chk("g_first", n_wr - w0, 1);
    repeat (16) tick();
    chk("g_held", n_wr - w0, 1);
    chk("g_req2", bus_req, 1);
    chk("g_z2", addr_bus, 16'hFFFF);
    bus_gnt = 1'b1;
    wait_idle("g_idle_to");
    chk("g_second", n_wr - w0, 2);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic r;
      cmd_valid = ($urandom_range(0, 2) == 0);
      cmd_data  = 8'($urandom);
      bus_gnt   = ($urandom_range(0, 7) != 0);
      wait_n    = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      r = cmd_ready;
      tick();
      if (cmd_valid && r) begin
        exp_q.push_back(cmd_data);
        n_push++;
      end
    end
    cmd_valid = 1'b0;
    bus_gnt = 1'b1;
    wait_n = 1'b1;
    wait_idle("r_drain_to");
    chk("r_left", exp_q.size(), 0);

    // reset during TW
    push(8'h5A);
    w0 = n_wr;
    wait_low("x_low_to");
    tick();
    wait_n = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("x_iorq", iorq_n, 1);
    chk("x_wr", wr_n, 1);
    chk("x_addr", addr_bus, 16'hFFFF);
    chk("x_data", data_bus, 8'hFF);
    chk("x_req", bus_req, 0);
    chk("x_busy", busy, 0);
    n_push = 0;
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    wait_n = 1'b1;
    repeat (30) tick();
    chk("x_nowrite", n_wr - w0, 0);
    chk("x_busy2", busy, 0);
    chk("x_ready", cmd_ready, 1);
    chk("x_iorq2", iorq_n, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
